// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake for the JK sequencer: valid/ready plus a {op, len} payload.
interface jk_cmd_sequencer_if #(
  parameter int unsigned LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Buffers JK commands, plays each onto registered J/K for len+1 cycles and
// checks the returned flip-flop q against an internal reference model.
module jk_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     res,
  jk_cmd_sequencer_if.slave        cmd,
  input  logic                     clr_err,
  input  logic                     q_in,
  output logic                     J,
  output logic                     K,
  output logic                     busy,
  output logic                     done,
  output logic                     model_q,
  output logic                     err,
  output logic [CNT_W-1:0]         err_count
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned EntryW = LEN_W + 2;

  typedef enum logic {StIdle, StDrive} state_e;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic              empty, full, push, pop;
  logic [EntryW-1:0] head;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              j_q, j_d, k_q, k_d;
  logic              model_q_q, model_q_d;
  logic              chk_q;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              mismatch;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign push  = cmd.cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q[PtrW-1:0]];

  assign cmd.cmd_ready = !full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= {cmd.cmd_op, cmd.cmd_len};
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    k_d     = k_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          j_d     = head[EntryW-1];
          k_d     = head[EntryW-2];
          cnt_d   = head[LEN_W-1:0];
          state_d = StDrive;
        end else begin
          j_d = 1'b0;
          k_d = 1'b0;
        end
      end
      StDrive: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!empty) begin
          // Back-to-back: next command starts with no gap cycle.
          pop   = 1'b1;
          j_d   = head[EntryW-1];
          k_d   = head[EntryW-2];
          cnt_d = head[LEN_W-1:0];
        end else begin
          j_d     = 1'b0;
          k_d     = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reference q follows the same J/K the flip-flop samples at this edge.
  always_comb begin
    model_q_d = model_q_q;
    unique case ({j_q, k_q})
      2'b01:   model_q_d = 1'b0;
      2'b10:   model_q_d = 1'b1;
      2'b11:   model_q_d = ~model_q_q;
      default: model_q_d = model_q_q;
    endcase
  end

  assign mismatch = chk_q && (q_in != model_q_q);

  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else if (mismatch) begin
      err_d = 1'b1;
      if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      model_q_q <= 1'b0;
      chk_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      model_q_q <= model_q_d;
      chk_q     <= 1'b1;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign J         = j_q;
  assign K         = k_q;
  assign busy      = (state_q == StDrive);
  assign done      = (state_q == StDrive) && (cnt_q == '0);
  assign model_q   = model_q_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Randomised and directed bench for jk_cmd_sequencer against a cycle-level
// command-queue model, with a behavioural JK flip-flop closing the loop.
module tb_jk_cmd_sequencer;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int          MaxCnt = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic res;
  logic clr_err;
  logic force_en, force_val;
  logic ff_q;
  wire  q_in = force_en ? force_val : ff_q;
  logic J, K, busy, done, model_q, err;
  logic [CNT_W-1:0] err_count;

  jk_cmd_sequencer_if #(.LEN_W(LEN_W)) cmd_if ();

  jk_cmd_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .res       (res),
    .cmd       (cmd_if),
    .clr_err   (clr_err),
    .q_in      (q_in),
    .J         (J),
    .K         (K),
    .busy      (busy),
    .done      (done),
    .model_q   (model_q),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Downstream JK flip-flop.
  always @(posedge clk or posedge res) begin
    if (res) ff_q <= 1'b0;
    else begin
      case ({J, K})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  logic q_s, res_s;
  always @(posedge clk) begin
    q_s   <= q_in;
    res_s <= res;
  end

  // Model state
  logic [LEN_W+1:0] m_fifo[$];
  int               rem;
  logic [1:0]       m_jk;
  logic             m_q, m_err, m_chk, m_push;
  int               m_cnt;

  int total = 0;
  int bad   = 0;

  logic [1:0] hist_jk[$];
  logic       hist_q[$];
  logic       hist_done[$];

  task automatic model_reset();
    m_fifo.delete();
    rem = 0; m_jk = 2'b00; m_q = 1'b0; m_err = 1'b0; m_chk = 1'b0;
    m_cnt = 0; m_push = 1'b0;
  endtask

  task automatic step();
    bit ready_pre, mism;
    logic [LEN_W+1:0] e;
    if (res_s) begin
      model_reset();
      return;
    end
    ready_pre = m_fifo.size() < DEPTH;
    mism = m_chk && (q_s !== m_q);
    if (clr_err) begin
      m_err = 1'b0; m_cnt = 0;
    end else if (mism) begin
      m_err = 1'b1;
      if (m_cnt < MaxCnt) m_cnt++;
    end
    m_chk = 1'b1;
    case (m_jk)
      2'b01:   m_q = 1'b0;
      2'b10:   m_q = 1'b1;
      2'b11:   m_q = ~m_q;
      default: m_q = m_q;
    endcase
    if (rem > 1) rem--;
    else if (m_fifo.size() > 0) begin
      e = m_fifo.pop_front();
      m_jk = e[LEN_W+1:LEN_W];
      rem = int'(e[LEN_W-1:0]) + 1;
    end else begin
      m_jk = 2'b00; rem = 0;
    end
    m_push = cmd_if.cmd_valid && ready_pre;
    if (m_push) m_fifo.push_back({cmd_if.cmd_op, cmd_if.cmd_len});
  endtask

  task automatic compare();
    logic [14:0] act, exp;
    act = {J, K, busy, done, cmd_if.cmd_ready, model_q, err, err_count};
    exp = {m_jk, rem > 0, rem == 1, m_fifo.size() < DEPTH, m_q, m_err, CNT_W'(m_cnt)};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cycle t=%0t got jk=%b busy=%b done=%b rdy=%b mq=%b err=%b cnt=%0d want jk=%b busy=%b done=%b rdy=%b mq=%b err=%b cnt=%0d",
               $time, act[14:13], act[12], act[11], act[10], act[9], act[8], act[7:0],
               exp[14:13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    step();
    compare();
    hist_jk.push_back({J, K});
    hist_q.push_back(ff_q);
    hist_done.push_back(done);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len);
    int n = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_len   = len;
    do begin
      cycle();
      n++;
    end while (!m_push && n < 200);
    cmd_if.cmd_valid = 1'b0;
    total++;
    if (!m_push) begin
      bad++;
      $display("FAIL push_timeout got=0 want=1");
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rem > 0 || m_fifo.size() > 0) && n < 500) begin
      cycle();
      n++;
    end
    cycle();
    total++;
    if (rem > 0 || m_fifo.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout got=busy want=idle");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 res = 1'b1;
    cycle();
    cycle();
    res = 1'b0;
    cycle();
  endtask

  logic [1:0] exp_jk [8] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
  logic       exp_q  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int idx, ndone;
    res = 1'b1; clr_err = 1'b0; force_en = 1'b0; force_val = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'b00; cmd_if.cmd_len = '0;
    model_reset();
    cycle();
    cycle();
    chk("reset_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    chk("reset_jk", {30'd0, J, K}, 32'd0);
    res = 1'b0;
    repeat (3) cycle();

    // Basic sequence with literal traces.
    hist_jk.delete(); hist_q.delete(); hist_done.delete();
    push_cmd(2'b10, 4'd1);
    push_cmd(2'b11, 4'd2);
    push_cmd(2'b01, 4'd0);
    push_cmd(2'b00, 4'd1);
    repeat (10) cycle();
    idx = -1;
    for (int i = 0; i < hist_jk.size(); i++) begin
      if (idx < 0 && hist_jk[i] == 2'b10) idx = i;
    end
    chk("basic_start_found", {31'd0, idx >= 0}, 32'd1);
    if (idx >= 0 && idx + 9 <= hist_jk.size()) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("basic_jk[%0d]", i), {30'd0, hist_jk[idx+i]}, {30'd0, exp_jk[i]});
        chk($sformatf("basic_q[%0d]", i), {31'd0, hist_q[idx+i+1]}, {31'd0, exp_q[i]});
      end
    end
    ndone = 0;
    foreach (hist_done[i]) if (hist_done[i] === 1'b1) ndone++;
    chk("basic_done_count", ndone, 32'd4);
    chk("basic_err", {31'd0, err}, 32'd0);

    // Reset mid-DRIVE with entries queued.
    push_cmd(2'b11, 4'd15);
    push_cmd(2'b10, 4'd15);
    push_cmd(2'b01, 4'd15);
    push_cmd(2'b11, 4'd15);
    repeat (2) cycle();
    #2 res = 1'b1;
    #1;
    chk("rst_async_jk", {30'd0, J, K}, 32'd0);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_done", {31'd0, done}, 32'd0);
    chk("rst_async_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    chk("rst_async_mq", {31'd0, model_q}, 32'd0);
    cycle();
    res = 1'b0;
    repeat (4) cycle();

    // Full / backpressure with back-to-back long commands.
    for (int k = 0; k < DEPTH + 2; k++) push_cmd(2'(k % 4), 4'd15);
    drain();

    // Forced mismatch, then clear.
    force_en = 1'b1; force_val = 1'b0;
    push_cmd(2'b10, 4'd3);
    drain();
    chk("mism_err", {31'd0, err}, 32'd1);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("clr_err", {31'd0, err}, 32'd0);
    chk("clr_cnt", {24'd0, err_count}, 32'd0);
    force_en = 1'b0;
    cycle();
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;

    // Saturation.
    force_en = 1'b1; force_val = ~m_q;
    repeat (300) cycle();
    chk("sat_cnt", {24'd0, err_count}, 32'd255);
    cycle();
    chk("sat_hold", {24'd0, err_count}, 32'd255);
    force_en = 1'b0;
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;

    // Idle gap between two single-cycle toggles.
    do_reset();
    push_cmd(2'b11, 4'd0);
    repeat (5) cycle();
    chk("gap_busy", {31'd0, busy}, 32'd0);
    push_cmd(2'b11, 4'd0);
    repeat (4) cycle();
    chk("gap_q_end", {31'd0, ff_q}, 32'd0);
    chk("gap_err", {31'd0, err}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cmd_if.cmd_valid = 1'($urandom % 2);
      cmd_if.cmd_op    = 2'($urandom % 4);
      cmd_if.cmd_len   = ($urandom % 8 == 0) ? 4'd15 : 4'($urandom % 4);
      clr_err          = ($urandom % 20 == 0);
      force_en         = ($urandom % 25 == 0);
      force_val        = 1'($urandom % 2);
      cycle();
    end
    cmd_if.cmd_valid = 1'b0; clr_err = 1'b0; force_en = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
